// File: rtl/shake_absorb_stream.sv
// Keccak sponge absorb engine: XORs 64-bit lanes into the rate, applies pad10*1, runs a permutation per block.
// One lane per cycle in ABSORB; in_ready is low while a permutation, pad or completion is in progress.
module shake_absorb_stream #(
    parameter int         STATE_WIDTH = 1600,
    parameter int         RATE_WIDTH  = 1088,
    parameter logic [7:0] DOMAIN      = 8'h1F
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   absorb_start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_lane,
    input  logic                   in_last,
    input  logic [3:0]             in_bytes,
    output logic                   perm_start,
    output logic [STATE_WIDTH-1:0] perm_state_out,
    input  logic                   perm_done,
    input  logic [STATE_WIDTH-1:0] perm_state_in,
    output logic [STATE_WIDTH-1:0] absorb_state_out,
    output logic                   absorb_done,
    output logic [2:0]             debug_absorb_state,
    output logic [15:0]            debug_block_cnt,
    output logic [STATE_WIDTH-1:0] debug_pre_perm
);
    localparam int RATE_LANES = RATE_WIDTH / 64;
    localparam int RATE_BYTES = RATE_WIDTH / 8;
    localparam int LIDX_W     = $clog2(RATE_LANES);
    localparam int BIDX_W     = $clog2(STATE_WIDTH);

    localparam logic [LIDX_W-1:0] LAST_LANE      = LIDX_W'(RATE_LANES - 1);
    localparam logic [BIDX_W-1:0] RATE_BYTES_W   = BIDX_W'(RATE_BYTES);
    localparam logic [BIDX_W-1:0] LAST_BYTE_BASE = BIDX_W'((RATE_BYTES - 1) * 8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABSORB = 3'd1,
        S_PERM   = 3'd2,
        S_PAD    = 3'd3,
        S_DONE   = 3'd4
    } fsm_e;

    fsm_e                   fsm_q, fsm_d;
    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [STATE_WIDTH-1:0] abs_out_q, abs_out_d;
    logic [STATE_WIDTH-1:0] pre_perm_q, pre_perm_d;
    logic [LIDX_W-1:0]      lane_idx_q, lane_idx_d;
    logic [15:0]            blk_cnt_q, blk_cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   perm_start_q, perm_start_d;
    logic                   absorb_done_q, absorb_done_d;
    logic                   pad_pending_q, pad_pending_d;
    logic                   final_q, final_d;

    logic [3:0]             nbytes;
    logic [63:0]            lane_mask;
    logic [BIDX_W-1:0]      lane_base;
    logic [BIDX_W-1:0]      off;
    logic [BIDX_W-1:0]      off_base;

    // Final-lane byte mask and pad offset; in_bytes saturates at a full lane.
    always_comb begin
        nbytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        for (int j = 0; j < 8; j++) begin
            lane_mask[8*j +: 8] = (4'(j) < nbytes) ? 8'hFF : 8'h00;
        end
        lane_base = BIDX_W'(lane_idx_q) << 6;
        off       = (BIDX_W'(lane_idx_q) << 3) + BIDX_W'(nbytes);
        off_base  = off << 3;
    end

    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        abs_out_d     = abs_out_q;
        pre_perm_d    = pre_perm_q;
        lane_idx_d    = lane_idx_q;
        blk_cnt_d     = blk_cnt_q;
        pad_pending_d = pad_pending_q;
        final_d       = final_q;

        case (fsm_q)
            S_IDLE: begin
                if (absorb_start) begin
                    state_d    = '0;
                    lane_idx_d = '0;
                    blk_cnt_d  = '0;
                    fsm_d      = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (in_valid && in_ready_q) begin
                    if (!in_last) begin
                        state_d[lane_base +: 64] = state_q[lane_base +: 64] ^ in_lane;
                        if (lane_idx_q == LAST_LANE) begin
                            lane_idx_d = '0;
                            final_d    = 1'b0;
                            fsm_d      = S_PERM;
                        end else begin
                            lane_idx_d = lane_idx_q + LIDX_W'(1);
                        end
                    end else begin
                        state_d[lane_base +: 64] = state_q[lane_base +: 64] ^ (in_lane & lane_mask);
                        lane_idx_d = '0;
                        fsm_d      = S_PERM;
                        // A message ending exactly on a block boundary needs a whole extra pad block.
                        if (off < RATE_BYTES_W) begin
                            state_d[off_base +: 8]       = state_d[off_base +: 8] ^ DOMAIN;
                            state_d[LAST_BYTE_BASE +: 8] = state_d[LAST_BYTE_BASE +: 8] ^ 8'h80;
                            final_d = 1'b1;
                        end else begin
                            pad_pending_d = 1'b1;
                            final_d       = 1'b0;
                        end
                    end
                end
            end
            S_PERM: begin
                if (perm_start_q) begin
                    pre_perm_d = state_q;
                    blk_cnt_d  = blk_cnt_q + 16'd1;
                end
                if (perm_done) begin
                    state_d = perm_state_in;
                    if (final_q) begin
                        abs_out_d = perm_state_in;
                        fsm_d     = S_DONE;
                    end else if (pad_pending_q) begin
                        fsm_d = S_PAD;
                    end else begin
                        fsm_d = S_ABSORB;
                    end
                end
            end
            S_PAD: begin
                state_d[7:0]                 = state_q[7:0] ^ DOMAIN;
                state_d[LAST_BYTE_BASE +: 8] = state_d[LAST_BYTE_BASE +: 8] ^ 8'h80;
                pad_pending_d = 1'b0;
                final_d       = 1'b1;
                fsm_d         = S_PERM;
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        in_ready_d    = (fsm_d == S_ABSORB);
        perm_start_d  = (fsm_d == S_PERM) && (fsm_q != S_PERM);
        absorb_done_d = (fsm_d == S_DONE) && (fsm_q != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q         <= S_IDLE;
            state_q       <= '0;
            abs_out_q     <= '0;
            pre_perm_q    <= '0;
            lane_idx_q    <= '0;
            blk_cnt_q     <= '0;
            in_ready_q    <= 1'b0;
            perm_start_q  <= 1'b0;
            absorb_done_q <= 1'b0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            abs_out_q     <= abs_out_d;
            pre_perm_q    <= pre_perm_d;
            lane_idx_q    <= lane_idx_d;
            blk_cnt_q     <= blk_cnt_d;
            in_ready_q    <= in_ready_d;
            perm_start_q  <= perm_start_d;
            absorb_done_q <= absorb_done_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
        end
    end

    assign in_ready           = in_ready_q;
    assign perm_start         = perm_start_q;
    assign perm_state_out     = state_q;
    assign absorb_state_out   = abs_out_q;
    assign absorb_done        = absorb_done_q;
    assign debug_absorb_state = fsm_q;
    assign debug_block_cnt    = blk_cnt_q;
    assign debug_pre_perm     = pre_perm_q;

endmodule

// File: tb/tb_shake_absorb_stream.sv
// Bench for shake_absorb_stream: two instances (SHAKE256/1F and rate 1344/06) behind identity stub cores.
// Expected states come from a byte-level pad10*1 sponge model with an identity permutation.
module tb_shake_absorb_stream;
    localparam int W = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           absorb_start [2];
    logic           in_valid     [2];
    logic           in_ready     [2];
    logic [63:0]    in_lane      [2];
    logic           in_last      [2];
    logic [3:0]     in_bytes     [2];
    logic           perm_start   [2];
    logic [W-1:0]   pso          [2];
    logic           perm_done    [2];
    logic [W-1:0]   psi          [2];
    logic [W-1:0]   aso          [2];
    logic           absorb_done  [2];
    logic [2:0]     dstate       [2];
    logic [15:0]    dcnt         [2];
    logic [W-1:0]   dpre         [2];

    shake_absorb_stream dut0 (
        .clk(clk), .reset(reset), .absorb_start(absorb_start[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_lane(in_lane[0]),
        .in_last(in_last[0]), .in_bytes(in_bytes[0]), .perm_start(perm_start[0]),
        .perm_state_out(pso[0]), .perm_done(perm_done[0]), .perm_state_in(psi[0]),
        .absorb_state_out(aso[0]), .absorb_done(absorb_done[0]),
        .debug_absorb_state(dstate[0]), .debug_block_cnt(dcnt[0]), .debug_pre_perm(dpre[0])
    );

    shake_absorb_stream #(.RATE_WIDTH(1344), .DOMAIN(8'h06)) dut1 (
        .clk(clk), .reset(reset), .absorb_start(absorb_start[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_lane(in_lane[1]),
        .in_last(in_last[1]), .in_bytes(in_bytes[1]), .perm_start(perm_start[1]),
        .perm_state_out(pso[1]), .perm_done(perm_done[1]), .perm_state_in(psi[1]),
        .absorb_state_out(aso[1]), .absorb_done(absorb_done[1]),
        .debug_absorb_state(dstate[1]), .debug_block_cnt(dcnt[1]), .debug_pre_perm(dpre[1])
    );

    // Identity core: done three cycles after start, returning the state seen at start.
    int           stub_cnt [2] = '{0, 0};
    logic [W-1:0] stub_cap [2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (perm_start[d]) begin
                stub_cnt[d] <= 3;
                stub_cap[d] <= pso[d];
            end else if (stub_cnt[d] != 0) begin
                stub_cnt[d] <= stub_cnt[d] - 1;
            end
        end
    end
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            perm_done[d] = (stub_cnt[d] == 1);
            psi[d]       = perm_done[d] ? stub_cap[d] : ~stub_cap[d];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        int p;
        checks++;
        if (got !== exp) begin
            errors++;
            p = 0;
            for (int i = 199; i >= 0; i--) begin
                if (got[8*i +: 8] !== exp[8*i +: 8]) p = i;
            end
            $display("FAIL %s: byte %0d got %h want %h", tag, p, got[8*p +: 8], exp[8*p +: 8]);
        end
    endtask

    // Monitor for the instance under test.
    int           cur = 0;
    logic [W-1:0] obs_pre[$];
    logic [W-1:0] obs_out;
    int           done_cnt = 0;
    int           acc_cnt = 0;
    logic         prev_start = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_start) obs_pre.push_back(dpre[cur]);
            prev_start = perm_start[cur];
            if (in_valid[cur] && in_ready[cur]) acc_cnt++;
            if (absorb_done[cur]) begin
                done_cnt++;
                obs_out = aso[cur];
            end
            if (stub_cnt[cur] != 0 || perm_start[cur]) chk("rdy_in_perm", W'(in_ready[cur]), W'(0));
        end
    end

    logic [7:0]   msg[$];
    logic [W-1:0] exp_pre[$];

    task automatic model(input int rb, input logic [7:0] dom);
        int           n;
        int           plen;
        logic [7:0]   pbuf[];
        logic [W-1:0] acc;
        n    = msg.size();
        plen = ((n + rb) / rb) * rb;
        pbuf = new[plen];
        for (int i = 0; i < plen; i++) pbuf[i] = (i < n) ? msg[i] : 8'h00;
        pbuf[n]      = pbuf[n] ^ dom;
        pbuf[plen-1] = pbuf[plen-1] ^ 8'h80;
        acc = '0;
        exp_pre.delete();
        for (int b = 0; b < plen / rb; b++) begin
            for (int p = 0; p < rb; p++) acc[8*p +: 8] = acc[8*p +: 8] ^ pbuf[b*rb + p];
            exp_pre.push_back(acc);
        end
    endtask

    task automatic drive_msg(input int d, input bit gaps, input bit empty_tail,
                             input bit big_bytes, output int nl);
        int          n;
        int          nb;
        bit          ok;
        logic [63:0] w;
        n  = msg.size();
        nl = (n == 0) ? 1 : (n + 7) / 8;
        if (empty_tail && n > 0 && n % 8 == 0) nl++;
        @(posedge clk); #1 absorb_start[d] = 1'b1;
        @(posedge clk); #1 absorb_start[d] = 1'b0;
        for (int k = 0; k < nl; k++) begin
            w = {$urandom(), $urandom()};
            for (int j = 0; j < 8; j++) begin
                if (k*8 + j < n) w[8*j +: 8] = msg[k*8 + j];
            end
            nb = n - k*8;
            if (nb > 8) nb = 8;
            if (nb < 0) nb = 0;
            in_lane[d] = w;
            in_last[d] = (k == nl - 1);
            if (k == nl - 1) in_bytes[d] = (big_bytes && nb == 8) ? 4'(8 + $urandom_range(1, 7)) : 4'(nb);
            else             in_bytes[d] = 4'($urandom_range(0, 15));
            in_valid[d] = 1'b1;
            ok = 1'b0;
            for (int g = 0; g < 200; g++) begin
                @(negedge clk);
                if (in_ready[d]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                chk("lane_accept_timeout", W'(0), W'(1));
                in_valid[d] = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid[d] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic run_case(input string name, input int d, input bit gaps,
                            input bit empty_tail, input bit big_bytes);
        int nl;
        bit seen;
        model(d ? 168 : 136, d ? 8'h06 : 8'h1F);
        obs_pre.delete();
        done_cnt = 0;
        acc_cnt  = 0;
        cur      = d;
        drive_msg(d, gaps, empty_tail, big_bytes, nl);
        seen = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            @(posedge clk);
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, W'(seen), W'(1));
        repeat (4) @(posedge clk);
        chk({name, "_nperm"}, W'(obs_pre.size()), W'(exp_pre.size()));
        for (int i = 0; i < obs_pre.size() && i < exp_pre.size(); i++)
            chk({name, "_pre"}, obs_pre[i], exp_pre[i]);
        chk({name, "_blkcnt"}, W'(dcnt[d]), W'(exp_pre.size()));
        chk({name, "_done_cnt"}, W'(done_cnt), W'(1));
        chk({name, "_out"}, obs_out, exp_pre[exp_pre.size() - 1]);
        chk({name, "_lanes"}, W'(acc_cnt), W'(nl));
    endtask

    task automatic check_idle_outputs(input string name, input int d);
        chk({name, "_fsm"}, W'(dstate[d]), W'(0));
        chk({name, "_rdy"}, W'(in_ready[d]), W'(0));
        chk({name, "_pstart"}, W'(perm_start[d]), W'(0));
        chk({name, "_adone"}, W'(absorb_done[d]), W'(0));
        chk({name, "_cnt"}, W'(dcnt[d]), W'(0));
        chk({name, "_pso"}, pso[d], W'(0));
        chk({name, "_aso"}, aso[d], W'(0));
        chk({name, "_pre"}, dpre[d], W'(0));
    endtask

    logic [W-1:0] tmp;
    bit           seen_done;

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            absorb_start[d] = 1'b0;
            in_valid[d]     = 1'b0;
            in_lane[d]      = '0;
            in_last[d]      = 1'b0;
            in_bytes[d]     = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst0", 0);
        check_idle_outputs("rst1", 1);

        msg.delete();
        run_case("empty", 0, 0, 0, 0);
        tmp = (obs_pre.size() > 0) ? obs_pre[0] : '0;
        chk("empty_b0", W'(tmp[7:0]), W'(8'h1F));
        chk("empty_b135", W'(tmp[1087:1080]), W'(8'h80));

        msg = '{8'h61, 8'h62, 8'h63};
        run_case("abc", 0, 0, 0, 0);
        tmp = (obs_pre.size() > 0) ? obs_pre[0] : '0;
        chk("abc_low", W'(tmp[31:0]), W'(32'h1F636261));

        msg.delete();
        for (int i = 0; i < 136; i++) msg.push_back(8'hFF);
        run_case("ff136", 0, 0, 0, 0);
        tmp = (obs_pre.size() > 1) ? obs_pre[1] : '0;
        chk("ff136_b0", W'(tmp[7:0]), W'(8'hE0));
        chk("ff136_b135", W'(tmp[1087:1080]), W'(8'h7F));

        msg.delete();
        for (int i = 0; i < 150; i++) msg.push_back(8'($urandom()));
        run_case("bp150", 0, 0, 0, 0);

        msg.delete();
        for (int i = 0; i < 167; i++) msg.push_back(8'($urandom()));
        run_case("r1344_167", 1, 0, 0, 0);
        tmp = (obs_pre.size() > 0) ? obs_pre[0] : '0;
        chk("r1344_b167", W'(tmp[1343:1336]), W'(8'h86));

        for (int t = 0; t < 14; t++) begin
            int len;
            int d;
            d = $urandom_range(0, 1);
            case (t % 7)
                0: len = 135;
                1: len = 136;
                2: len = 168;
                3: len = 272;
                default: len = $urandom_range(0, 350);
            endcase
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom()));
            run_case("rand", d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort in PERM; the stub's done pulse then arrives while idle.
        msg.delete();
        for (int i = 0; i < 136; i++) msg.push_back(8'($urandom()));
        cur = 0;
        begin
            int nl;
            drive_msg(0, 0, 0, 0, nl);
        end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        seen_done = 1'b0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (perm_done[0]) begin
                seen_done = 1'b1;
                break;
            end
        end
        chk("rst_stale_done", W'(seen_done), W'(1));
        @(negedge clk);
        check_idle_outputs("rst_perm", 0);

        msg.delete();
        run_case("post_rst_empty", 0, 0, 0, 0);
        tmp = (obs_pre.size() > 0) ? obs_pre[0] : '0;
        chk("post_rst_b0", W'(tmp[7:0]), W'(8'h1F));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shake_absorb_stream.md
Name: shake_absorb_stream

Overview:
- Streaming, parametrised absorb engine for the Keccak sponge (SHAKE128/256, SHA3-x).
- Accepts the message as 64-bit lanes over a valid/ready handshake, XORs each lane into the rate portion of the state, and applies pad10*1 with a configurable domain suffix.
- Drives an external Keccak-f[1600] core through a start/done handshake for every full block and for the final padded block.
- Sits between the message front-end and the permutation core. Presents the absorbed state to the squeeze stage.

Parameters:
- STATE_WIDTH, 1600, sponge state width in bits; fixed for Keccak-f[1600].
- RATE_WIDTH, 1088, rate in bits; must be a multiple of 64 and less than STATE_WIDTH. Use 1088 for SHAKE256 and 1344 for SHAKE128.
- DOMAIN, 8'h1F, domain-separation byte XORed at the pad position. Use 8'h1F for SHAKE and 8'h06 for SHA3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- absorb_start  in  1  one-cycle pulse; starts a new message from a zero state
- in_valid  in  1  lane valid
- in_ready  out  1  lane accepted when in_valid && in_ready
- in_lane  in  64  message lane; byte j occupies bits [8j+7:8j]
- in_last  in  1  marks the final lane of the message
- in_bytes  in  4  valid bytes in the final lane, 0..8; only the low bytes are used; ignored when in_last=0
- perm_start  out  1  one-cycle pulse requesting a permutation of perm_state_out
- perm_state_out  out  1600  state handed to the core; equals the internal state
- perm_done  in  1  one-cycle pulse from the core; perm_state_in is valid in that cycle
- perm_state_in  in  1600  permuted state returned by the core
- absorb_state_out  out  1600  registered absorbed state; valid from absorb_done onward
- absorb_done  out  1  one-cycle pulse when absorption is complete
- debug_absorb_state  out  3  FSM state encoding
- debug_block_cnt  out  16  permutations issued for the current message
- debug_pre_perm  out  1600  state captured at the most recent perm_start

Behaviour:
- Reset: FSM goes to IDLE; state, absorb_state_out, debug_pre_perm, lane_idx and debug_block_cnt clear to 0; in_ready, perm_start, absorb_done and pad_pending clear to 0.
- Reset mid-operation aborts the message. Any later perm_done is ignored.
- Bit layout: byte position p maps to state bits [8p+7:8p]; lane i maps to bits [64i+63:64i]. RATE_LANES = RATE_WIDTH/64 and RATE_BYTES = RATE_WIDTH/8.
- IDLE:
  - in_ready=0.
  - absorb_start: state<=0, lane_idx<=0, debug_block_cnt<=0, then go to ABSORB.
- ABSORB:
  - in_ready=1.
  - On an accepted lane that is not last: state lane lane_idx ^= in_lane, then lane_idx++.
  - If that lane was RATE_LANES-1, go to PERM with final=0 and lane_idx<=0.
- ABSORB, accepted last lane:
  - XOR only bytes 0..in_bytes-1 of in_lane.
  - Compute off = lane_idx*8 + in_bytes.
  - If off < RATE_BYTES: state byte off ^= DOMAIN and byte RATE_BYTES-1 ^= 8'h80, in the same cycle. If the two positions coincide the byte receives DOMAIN^8'h80. Then go to PERM with final=1.
  - If off == RATE_BYTES: set pad_pending and go to PERM with final=0.
- PERM:
  - On the entry cycle: perm_start=1, debug_pre_perm<=state, debug_block_cnt++.
  - Wait for perm_done, then state<=perm_state_in.
  - Next state: DONE if final; PAD if pad_pending; otherwise ABSORB.
  - in_ready=0 throughout, so upstream must hold in_valid with stable data.
- PAD: state byte 0 ^= DOMAIN and byte RATE_BYTES-1 ^= 8'h80; clear pad_pending; go to PERM with final=1.
- DONE: absorb_state_out<=state, absorb_done=1 for one cycle, then return to IDLE. absorb_state_out holds until the next absorb_start or reset.
- Ignored inputs:
  - absorb_start outside IDLE.
  - perm_done outside PERM.
  - in_valid outside ABSORB.
- The capacity bits, RATE_WIDTH and above, are never modified by absorb logic; only the core changes them.
- in_bytes > 8 is treated as 8.

Test Plan:
Bench drives an identity stub core that asserts perm_done 3 cycles after perm_start.
- Empty message: a single lane with in_last=1, in_bytes=0, default params → exactly 1 perm_start. debug_pre_perm byte0=8'h1F, byte135=8'h80, all other bits 0. absorb_done pulses once.
- 3-byte message 0x636261 ("abc"): bytes 0..2 = 61 62 63, byte3=8'h1F, byte135=8'h80, capacity 0.
- 136-byte all-0xFF message (17 full lanes, last in_bytes=8) → 2 perm_starts. The second debug_pre_perm has the rate all-ones except byte0=8'hE0 and byte135=8'h7F. debug_block_cnt=2.
- Backpressure: hold in_valid=1 across a 17+ lane stream → in_ready low for every PERM cycle, no lane lost or duplicated; per-lane XOR checked against a scoreboard.
- RATE_WIDTH=1344, DOMAIN=8'h06, message of 167 bytes → pad byte 167 = 8'h86, 1 permutation.
- Assert reset while in PERM, then pulse perm_done → no state update, FSM IDLE, all outputs 0. A fresh empty message afterwards passes the first scenario.
